// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect from execute,
// and the valid/ready handoff to decode.
interface instr_fetch_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 10
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;
    logic               halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid,
        input  id_ready,
        output id_instr, id_pc, halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_instr, id_pc, halted
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, reads a synchronous instruction memory and buffers
// returned words with their PCs for decode; halts on opcode 111, restarts on redirect.
module instr_fetch_stage_chk #(
    parameter int CW         = 2,
    parameter int FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    input logic          push,
    input logic [CW-1:0] count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    a_no_push_into_full: assert property (@(posedge clk) disable iff (reset) push |-> (count < DEPTH_C));
endmodule

module instr_fetch_stage #(
    parameter int                ADDR_W     = 10,
    parameter int                INSTR_W    = 10,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
    localparam int             PW      = $clog2(FIFO_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [2:0]     OP_HALT = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  req_pc_r;
    logic               inflight_r;
    logic               halted_r;
    logic [CW-1:0]      count_r;
    logic [PW-1:0]      head_r;
    logic [PW-1:0]      tail_r;
    logic [INSTR_W-1:0] fifo_instr_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc_r    [FIFO_DEPTH];

    logic               valid_s;
    logic [CW-1:0]      occupancy_s;
    logic               req_s;
    logic               push_s;
    logic               pop_s;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return (word[INSTR_W-1 -: 3] == OP_HALT);
    endfunction

    // Request/push/pop decisions; a request is only made when its reply is sure to fit.
    always_comb begin
        valid_s     = (count_r != {CW{1'b0}});
        occupancy_s = count_r + {{(CW-1){1'b0}}, inflight_r};
        req_s       = !reset && (state_r == ST_RUN) && !bus.redirect_valid && (occupancy_s < DEPTH_C);
        push_s      = inflight_r && (state_r == ST_RUN) && !bus.redirect_valid;
        pop_s       = valid_s && bus.id_ready;
    end

    // PC, in-flight tracking, FIFO storage, run/halt state and the sticky halted flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_RUN;
            pc_r       <= RESET_PC;
            req_pc_r   <= RESET_PC;
            inflight_r <= 1'b0;
            halted_r   <= 1'b0;
            count_r    <= {CW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_r[i] <= {INSTR_W{1'b0}};
                fifo_pc_r[i]    <= {ADDR_W{1'b0}};
            end
        end else begin
            // A pop in the redirect cycle is a real handoff, so halted is evaluated first.
            if (pop_s && is_halt(fifo_instr_r[head_r])) begin
                halted_r <= 1'b1;
            end
            if (bus.redirect_valid) begin
                state_r    <= ST_RUN;
                pc_r       <= bus.redirect_pc;
                inflight_r <= 1'b0;
                count_r    <= {CW{1'b0}};
                head_r     <= {PW{1'b0}};
                tail_r     <= {PW{1'b0}};
            end else begin
                inflight_r <= req_s;
                if (req_s) begin
                    pc_r     <= pc_r + ADDR_W'(1);
                    req_pc_r <= pc_r;
                end
                if (push_s) begin
                    fifo_instr_r[tail_r] <= bus.imem_rdata;
                    fifo_pc_r[tail_r]    <= req_pc_r;
                    tail_r               <= tail_r + PW'(1);
                    if (is_halt(bus.imem_rdata)) begin
                        state_r <= ST_HALT;
                    end
                end
                if (pop_s) begin
                    head_r <= head_r + PW'(1);
                end
                count_r <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
            end
        end
    end

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc_r;
    assign bus.id_valid  = valid_s;
    assign bus.id_instr  = fifo_instr_r[head_r];
    assign bus.id_pc     = fifo_pc_r[head_r];
    assign bus.halted    = halted_r;

    instr_fetch_stage_chk #(
        .CW         (CW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .count (count_r)
    );
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: transaction-level queue model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_instr_fetch_stage;
    localparam int AW    = 10;
    localparam int IW    = 10;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instr_fetch_stage #(
        .ADDR_W     (AW),
        .INSTR_W    (IW),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (10'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } entry_t;

    logic [IW-1:0] imem [1024];
    entry_t        m_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_pend_pc;
    logic          m_run;
    logic          m_pend;
    logic          m_halted;
    logic          env_req;
    logic [AW-1:0] env_addr;
    logic [AW-1:0] delivered[$];
    logic [AW-1:0] req_log[$];
    int            cyc;
    int            first_valid;
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = 10'd0;
        m_pend_pc = 10'd0;
        m_run     = 1'b1;
        m_pend    = 1'b0;
        m_halted  = 1'b0;
        env_req   = 1'b0;
        env_addr  = 10'd0;
        delivered.delete();
        req_log.delete();
        cyc         = 0;
        first_valid = -1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 10'd0;
        bus.id_ready       = 1'b0;
        bus.imem_rdata     = 10'd0;
        @(posedge clk); #1;
        check("rst_imem_req",  bus.imem_req,  32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'd0);
        check("rst_id_valid",  bus.id_valid,  32'd0);
        check("rst_id_instr",  bus.id_instr,  32'd0);
        check("rst_id_pc",     bus.id_pc,     32'd0);
        check("rst_halted",    bus.halted,    32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input logic rv, input logic [AW-1:0] rpc, input logic rdy);
        logic   exp_req;
        logic   pop;
        entry_t e;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        bus.imem_rdata     = env_req ? imem[env_addr] : IW'($urandom);
        #2;
        exp_req = m_run && !rv && ((m_q.size() + int'(m_pend)) < DEPTH);
        check("imem_req",  bus.imem_req,  exp_req);
        check("imem_addr", bus.imem_addr, m_pc);
        check("id_valid",  bus.id_valid,  (m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("id_instr", bus.id_instr, m_q[0].instr);
            check("id_pc",    bus.id_pc,    m_q[0].pc);
        end
        check("halted", bus.halted, m_halted);
        if (bus.id_valid && first_valid < 0) first_valid = cyc;
        if (bus.id_valid && rdy) delivered.push_back(bus.id_pc);
        if (bus.imem_req) req_log.push_back(bus.imem_addr);
        env_req  = bus.imem_req;
        env_addr = bus.imem_addr;

        pop = (m_q.size() != 0) && rdy;
        if (pop && (m_q[0].instr[IW-1 -: 3] == 3'b111)) m_halted = 1'b1;
        if (rv) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = rpc;
            m_run  = 1'b1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend && m_run) begin
                e.instr = imem[m_pend_pc];
                e.pc    = m_pend_pc;
                m_q.push_back(e);
                check("fifo_bound", (m_q.size() <= DEPTH), 32'd1);
                if (e.instr[IW-1 -: 3] == 3'b111) m_run = 1'b0;
            end
            m_pend = exp_req;
            if (exp_req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 10'd1;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 10'd0, rdy);
    endtask

    task automatic load_addi(input int start, input int n);
        for (int i = 0; i < n; i++) imem[(start + i) % 1024] = {3'b001, 7'(i + 1)};
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) begin
            imem[i] = {3'($urandom_range(0, 6)), 7'($urandom)};
            if ($urandom_range(0, 9) == 0) imem[i][IW-1 -: 3] = 3'b111;
        end
    endtask

    initial begin
        int npre;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 10'd0;
        bus.id_ready       = 1'b0;
        bus.imem_rdata     = 10'd0;
        for (int i = 0; i < 1024; i++) imem[i] = {3'b001, 7'(i)};

        // Straight-line program ending in a halt word at PC 6
        load_addi(0, 6);
        imem[6] = {3'b111, 7'd0};
        apply_reset();
        run(16, 1'b1);
        check("s1_first_valid_cycle", first_valid, 32'd2);
        check("s1_count", delivered.size(), 32'd7);
        for (int i = 0; i < 7 && i < delivered.size(); i++) check("s1_pc_order", delivered[i], i);
        check("s1_req_count", req_log.size(), 32'd8);
        if (req_log.size() == 8) check("s1_last_req", req_log[7], 32'd7);
        check("s1_halted", bus.halted, 32'd1);
        check("s1_req_off", bus.imem_req, 32'd0);

        // Redirect while halted resumes at 4; halted stays set
        delivered.delete();
        cycle(1'b1, 10'd4, 1'b1);
        run(10, 1'b1);
        check("s6_count", delivered.size(), 32'd3);
        for (int i = 0; i < 3 && i < delivered.size(); i++) check("s6_pc", delivered[i], 4 + i);
        check("s6_halted", bus.halted, 32'd1);

        // Decode stalls right after the first valid
        load_addi(0, 10);
        apply_reset();
        run(12, 1'b0);
        check("s2_req_stalled", bus.imem_req, 32'd0);
        check("s2_valid", bus.id_valid, 32'd1);
        check("s2_head_pc", bus.id_pc, 32'd0);
        check("s2_buffered", req_log.size(), 32'd2);
        run(8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < delivered.size()) check("s2_pc", delivered[i], i);
            else check("s2_missing", delivered.size(), 32'd4);
        end

        // Redirect to 3 with buffered entries and a fetch in flight
        apply_reset();
        run(7, 1'b1);
        run(6, 1'b0);
        npre = delivered.size();
        for (int i = 0; i < npre; i++) check("s3_pre_pc", delivered[i], i);
        delivered.delete();
        cycle(1'b1, 10'd3, 1'b0);
        run(10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < delivered.size()) check("s3_post_pc", delivered[i], 3 + i);
            else check("s3_missing", delivered.size(), 32'd4);
        end

        // Address wrap from 1022
        load_addi(1022, 5);
        apply_reset();
        cycle(1'b1, 10'd1022, 1'b1);
        run(10, 1'b1);
        check("s4_count_ge4", (delivered.size() >= 4), 32'd1);
        if (delivered.size() >= 4) begin
            check("s4_pc0", delivered[0], 32'd1022);
            check("s4_pc1", delivered[1], 32'd1023);
            check("s4_pc2", delivered[2], 32'd0);
            check("s4_pc3", delivered[3], 32'd1);
        end

        // Asynchronous reset with the FIFO full
        load_addi(0, 10);
        apply_reset();
        run(10, 1'b0);
        check("s5_full_valid", bus.id_valid, 32'd1);
        reset = 1'b1;
        #1;
        check("s5_async_valid", bus.id_valid, 32'd0);
        check("s5_async_req",   bus.imem_req, 32'd0);
        apply_reset();
        run(6, 1'b1);
        check("s5_restart_nonempty", (delivered.size() > 0), 32'd1);
        if (delivered.size() > 0) check("s5_restart_pc", delivered[0], 32'd0);

        // Randomized traffic against the model
        fill_random();
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                cycle(($urandom_range(0, 99) < 6), 10'($urandom), ($urandom_range(0, 3) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
